vec_ram_reader: RTL and testbench

Streaming read engine for one port of the vector-unit dual-port RAM. Given a base address and element count, it issues sequential reads to the RAM port, absorbs the RAM's one-cycle registered read latency, and presents elements on a valid/ready stream with last-element marking and full backpressure. Sits between the vector scratch RAM and downstream lane/compute logic; the other RAM port stays free for a writer.

---
 rtl/vpu_mem_pkg.sv | 20 ++
 rtl/vec_rd_skid.sv | 52 +++++
 rtl/vec_ram_reader.sv | 159 +++++++++++++++
 tb/tb_vec_ram_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vpu_mem_pkg
//  Description : Shared types and default widths for the vector-unit RAM
//                access engines.
//  Revision    : 1.0 - initial release
// ============================================================================
package vpu_mem_pkg;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/vec_rd_skid.sv
`default_nettype none
// ============================================================================
//  Module      : vec_rd_skid
//  Description : Two-entry valid/ready FIFO buffer; exposes its occupancy so
//                the producer can run credit-based flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_rd_skid
    import vpu_mem_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    logic                  w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/vec_ram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : vec_ram_reader
//  Description : Streams len elements from a RAM port starting at base_addr
//                onto a valid/ready interface with last marking.
//                Optional macro VEC_RD_STRIDE_EN adds a programmable stride.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_ram_reader
    import vpu_mem_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef VEC_RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [ADDR_WIDTH:0]   r_issue_cnt;
    logic [ADDR_WIDTH:0]   r_out_cnt;
    logic                  r_inflight;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic [1:0]            w_occ;
    logic [2:0]            w_pending;
    logic [ADDR_WIDTH-1:0] w_inc;

`ifdef VEC_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0] r_stride;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stride <= '0;
        end else if (w_accept) begin
            r_stride <= stride;
        end
    end

    assign w_inc = r_stride;
`else
    assign w_inc = c_ADDR_ONE;
`endif

    assign w_accept = (r_state == IDLE) && start;
    assign w_pop    = m_valid && m_ready;

    // Buffered plus in-flight reads, minus the one leaving now, must stay
    // below the buffer depth so a returning read always has a slot.
    assign w_pending   = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_credit_ok = (w_pending - {2'b00, w_pop}) < 3'd2;
    assign w_issue     = (r_state == RUN) && (r_issue_cnt != '0) && w_credit_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_issue && (r_issue_cnt == c_CNT_ONE)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && (r_out_cnt == c_CNT_ONE)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_addr_hold <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_inflight <= w_issue;
            if (w_accept) begin
                r_addr      <= base_addr;
                r_issue_cnt <= len;
                r_out_cnt   <= len;
            end else begin
                if (w_issue) begin
                    r_addr      <= r_addr + w_inc;
                    r_addr_hold <= r_addr;
                    r_issue_cnt <= r_issue_cnt - c_CNT_ONE;
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt - c_CNT_ONE;
                end
            end
        end
    end

    vec_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (ram_dout),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_count (w_occ)
    );

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign ram_we   = 1'b0;
    assign ram_din  = '0;
    assign ram_addr = w_issue ? r_addr : r_addr_hold;
    assign m_valid  = (w_occ != 2'd0);
    assign m_last   = m_valid && (r_out_cnt == c_CNT_ONE);

endmodule
`default_nettype wire

// File: tb/tb_vec_ram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_ram_reader
//  Description : Self-checking bench for vec_ram_reader with a behavioural RAM
//                and an element-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_ram_reader;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
`ifdef VEC_RD_STRIDE_EN
    logic [AW-1:0] stride;
`endif
    logic          busy;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    logic [DW-1:0] mem [DEPTH];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= mem[ram_addr];

    vec_ram_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef VEC_RD_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command: rmode 0 = ready always high, 1 = 1,0,0,1 pattern, 2 = random.
    // Expected element k is mem[(base + k*strd) mod DEPTH].
    task automatic run_cmd(input int base, input int n, input int strd,
                           input int rmode, input bit timing, input bit inj);
        int          k;
        int          cyc;
        bit          done_seen;
        bit          prev_stall;
        logic [DW-1:0] prev_data;
        logic        prev_last;
        logic [DW-1:0] exp_data;

        base_addr = AW'(base);
        len       = (AW+1)'(n);
`ifdef VEC_RD_STRIDE_EN
        stride    = AW'(strd);
`endif
        start     = 1'b1;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        cyc        = 1;
        k          = 0;
        done_seen  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (!done_seen && cyc < 5000) begin
            start = inj && (cyc == 2);
            if (start) begin
                base_addr = AW'($urandom);
                len       = (AW+1)'(5);
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                default: m_ready = 1'($urandom);
            endcase
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_after_start", 32'(busy), (n > 0) ? 32'd1 : 32'd0);
                if (timing && n > 0) check("first_addr", 32'(ram_addr), 32'(base % DEPTH));
            end
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
                check("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (n == 0) check("len0_no_valid", 32'(m_valid), 32'd0);
            if (m_valid && m_ready) begin
                exp_data = mem[(base + k * strd) % DEPTH];
                check("elem_data", 32'(m_data), 32'(exp_data));
                check("elem_last", 32'(m_last), (k == n - 1) ? 32'd1 : 32'd0);
                if (timing) check("elem_cycle", 32'(cyc), 32'(3 + k));
                k++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (done) begin
                done_seen = 1'b1;
                check("elem_count", 32'(k), 32'(n));
                check("busy_at_done", 32'(busy), 32'd0);
                if (timing) check("done_cycle", 32'(cyc), (n > 0) ? 32'(3 + n) : 32'd1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        m_ready   = 1'b0;
        base_addr = '0;
        len       = '0;
`ifdef VEC_RD_STRIDE_EN
        stride    = '0;
`endif
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(32'h010, 4, 1, 0, 1'b1, 1'b0);
        run_cmd(32'h3FE, 4, 1, 0, 1'b1, 1'b0);
        run_cmd(32'h020, 6, 1, 1, 1'b0, 1'b0);
        run_cmd(32'h055, 0, 1, 0, 1'b1, 1'b0);
        run_cmd(32'h0A0, 5, 1, 0, 1'b1, 1'b1);
        run_cmd(32'h200, 1, 1, 0, 1'b1, 1'b0);

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int t = 0; t < 8; t++) begin
            run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 1,
                    (t % 2 == 0) ? 2 : 1, 1'b0, 1'b0);
        end
        run_cmd(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1, 2, 1'b0, 1'b0);
        run_cmd(int'($urandom_range(0, DEPTH - 1)), 16, 1, 0, 1'b1, 1'b0);

        // Reset in the middle of a long command.
        base_addr = AW'(12'h100);
        len       = (AW+1)'(8);
        start     = 1'b1;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_quiet", {30'd0, done, m_valid}, 32'd0);
        end
        @(posedge clk); #1;
        run_cmd(int'($urandom_range(0, DEPTH - 1)), 2, 1, 0, 1'b1, 1'b0);

`ifdef VEC_RD_STRIDE_EN
        run_cmd(0, 4, 3, 0, 1'b1, 1'b0);
        run_cmd(32'h3F0, 7, 5, 1, 1'b0, 1'b0);
        run_cmd(32'h123, 3, 0, 0, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
